// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of an N-input combinational block, drives the golden
// output from a latched truth table, and scores the block's response.
module truth_table_sweeper #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2**N-1:0] mask,
  input  logic            pause,
  input  logic            dut_y,
  output logic [N-1:0]    vec,
  output logic            y,
  output logic            valid,
  output logic            busy,
  output logic            done,
  output logic [N:0]      ones_count,
  output logic [N:0]      mismatch_count,
  output logic            err_flag,
  output logic [N-1:0]    first_err_vec
);

  localparam int V  = 2**N;
  localparam int CW = N + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [V-1:0]    mask_reg, mask_next;
  logic [N-1:0]    vec_reg, vec_next;
  logic [CW-1:0]   ones_reg, ones_next;
  logic [CW-1:0]   mism_reg, mism_next;
  logic            err_reg, err_next;
  logic [N-1:0]    first_reg, first_next;
  logic            valid_reg, valid_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            golden;

  assign golden = mask_reg[vec_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      vec_reg   <= '0;
      ones_reg  <= '0;
      mism_reg  <= '0;
      err_reg   <= 1'b0;
      first_reg <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      vec_reg   <= vec_next;
      ones_reg  <= ones_next;
      mism_reg  <= mism_next;
      err_reg   <= err_next;
      first_reg <= first_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    vec_next   = vec_reg;
    ones_next  = ones_reg;
    mism_next  = mism_reg;
    err_next   = err_reg;
    first_next = first_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mask_next  = mask;
          vec_next   = '0;
          ones_next  = '0;
          mism_next  = '0;
          err_next   = 1'b0;
          first_next = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!pause) begin
          ones_next = ones_reg + CW'(golden);
          if (dut_y != golden) begin
            mism_next = mism_reg + CW'(1);
            if (!err_reg) begin
              err_next   = 1'b1;
              first_next = vec_reg;
            end
          end
          // Last vector keeps its value so the sweep end is visible afterwards
          if (vec_reg == N'(V - 1)) state_next = DONE;
          else                      vec_next   = vec_reg + N'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the upcoming state so they align with it
  assign valid_next = (state_next == RUN);
  assign busy_next  = (state_next != IDLE);
  assign done_next  = (state_next == DONE);

  assign vec            = vec_reg;
  assign y              = golden;
  assign valid          = valid_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign ones_count     = ones_reg;
  assign mismatch_count = mism_reg;
  assign err_flag       = err_reg;
  assign first_err_vec  = first_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a transaction-level reference model checked every
// cycle for the N=4 instance, plus directed literal checks on both instances.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start, pause, dut_y;
  logic [15:0] mask_in;
  logic [3:0]  vec;
  logic        y, valid, busy, done, err_flag;
  logic [4:0]  ones_count, mismatch_count;
  logic [3:0]  first_err_vec;
  int          mode;

  logic        start2, dut_y2;
  logic [3:0]  mask2;
  logic [1:0]  vec2;
  logic        y2, valid2, busy2, done2, err2;
  logic [2:0]  ones2, mis2;
  logic [1:0]  first2;

  int errors = 0;
  int checks = 0;

  truth_table_sweeper #(.N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mask(mask_in), .pause(pause),
    .dut_y(dut_y), .vec(vec), .y(y), .valid(valid), .busy(busy), .done(done),
    .ones_count(ones_count), .mismatch_count(mismatch_count),
    .err_flag(err_flag), .first_err_vec(first_err_vec)
  );

  truth_table_sweeper #(.N(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mask(mask2), .pause(1'b0),
    .dut_y(dut_y2), .vec(vec2), .y(y2), .valid(valid2), .busy(busy2), .done(done2),
    .ones_count(ones2), .mismatch_count(mis2),
    .err_flag(err2), .first_err_vec(first2)
  );

  // mode 0: DUT echoes golden output; mode 1: DUT output stuck at 0
  assign dut_y  = (mode == 0) ? y : 1'b0;
  assign dut_y2 = vec2[1] ^ vec2[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep described as phase / position / tallies
  int          m_phase = 0;   // 0 idle, 1 sweeping, 2 finishing
  int          m_vec = 0, m_ones = 0, m_mis = 0, m_first = 0;
  bit          m_err = 0;
  logic [15:0] m_mask = '0;
  logic        s_rst_n, s_start, s_pause, s_dut_y;
  logic [15:0] s_mask;

  always begin
    @(negedge clk);
    chk("m_vec",   32'(vec),            32'(m_vec));
    chk("m_y",     32'(y),              32'(m_mask[m_vec]));
    chk("m_valid", 32'(valid),          32'(m_phase == 1));
    chk("m_busy",  32'(busy),           32'(m_phase != 0));
    chk("m_done",  32'(done),           32'(m_phase == 2));
    chk("m_ones",  32'(ones_count),     32'(m_ones));
    chk("m_mis",   32'(mismatch_count), 32'(m_mis));
    chk("m_err",   32'(err_flag),       32'(m_err));
    chk("m_first", 32'(first_err_vec),  32'(m_first));
    #4;
    s_rst_n = rst_n; s_start = start; s_pause = pause; s_dut_y = dut_y; s_mask = mask_in;
    @(posedge clk);
    if (!s_rst_n) begin
      m_phase = 0; m_vec = 0; m_ones = 0; m_mis = 0; m_first = 0; m_err = 0; m_mask = '0;
    end else if (m_phase == 0) begin
      if (s_start) begin
        m_phase = 1; m_mask = s_mask; m_vec = 0;
        m_ones = 0; m_mis = 0; m_err = 0; m_first = 0;
      end
    end else if (m_phase == 1) begin
      if (!s_pause) begin
        m_ones += int'(m_mask[m_vec]);
        if (s_dut_y != m_mask[m_vec]) begin
          m_mis++;
          if (!m_err) begin m_err = 1; m_first = m_vec; end
        end
        if (m_vec == 15) m_phase = 2;
        else m_vec++;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Start a sweep, optionally stall at one vector; returns cycle of done relative to start edge
  task automatic run_sweep(input logic [15:0] m, input int md, input int pause_vec,
                           input int pause_len, output int dc);
    bit found = 0, pausing = 0, paused_once = 0;
    int rem = 0;
    dc = -1;
    @(negedge clk); #1;
    mask_in = m; mode = md; start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done === 1'b1 && !found) begin found = 1; dc = i; end
      if (pausing) begin chk("pause_hold_vec", 32'(vec), 32'(pause_vec)); rem--; end
      #1;
      if (i == 1) begin start = 1'b0; mask_in = ~m; end
      if (pausing && rem == 0) begin pause = 1'b0; pausing = 0; end
      else if (!paused_once && pause_len > 0 && !pausing && int'(vec) == pause_vec) begin
        pause = 1'b1; pausing = 1; paused_once = 1; rem = pause_len;
      end
      if (found) break;
    end
    if (!found) chk("sweep_timeout", 32'(0), 32'(1));
    $display("sweep mask=%04h mode=%0d done_cycle=%0d ones=%0d mis=%0d err=%0d first=%0d",
             m, md, dc, ones_count, mismatch_count, err_flag, first_err_vec);
  endtask

  task automatic wait_vec(input int target);
    bit hit = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid === 1'b1 && int'(vec) == target) begin hit = 1; break; end
    end
    if (!hit) chk("wait_vec_timeout", 32'(0), 32'(1));
  endtask

  int dc;
  int q[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; mask_in = '0; mode = 0;
    start2 = 1'b0; mask2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_vec", 32'(vec), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_y", 32'(y), 0);
    #1 rst_n = 1'b1;

    run_sweep(16'h8001, 0, -1, 0, dc);
    chk("t1_done_cycle", 32'(dc), 17);
    chk("t1_ones", 32'(ones_count), 2);
    chk("t1_mis", 32'(mismatch_count), 0);
    chk("t1_err", 32'(err_flag), 0);

    run_sweep(16'h00F0, 1, -1, 0, dc);
    chk("t2_done_cycle", 32'(dc), 17);
    chk("t2_ones", 32'(ones_count), 4);
    chk("t2_mis", 32'(mismatch_count), 4);
    chk("t2_err", 32'(err_flag), 1);
    chk("t2_first", 32'(first_err_vec), 4);
    repeat (2) @(negedge clk);
    chk("t2_results_hold", 32'(mismatch_count), 4);
    chk("t2_vec_last", 32'(vec), 15);

    run_sweep(16'hFFFF, 0, 3, 5, dc);
    chk("t3_done_cycle", 32'(dc), 22);
    chk("t3_ones", 32'(ones_count), 16);
    chk("t3_mis", 32'(mismatch_count), 0);

    // Restart attempt mid-sweep, then reset mid-sweep
    @(negedge clk); #1;
    mask_in = 16'h1234; mode = 0; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_vec(6);
    #1 start = 1'b1; mask_in = 16'hFFFF;
    @(negedge clk); #1 start = 1'b0;
    wait_vec(9);
    chk("t4_ones_at_9", 32'(ones_count), 3);
    chk("t4_busy_at_9", 32'(busy), 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_vec", 32'(vec), 0);
    chk("t4_rst_valid", 32'(valid), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_ones", 32'(ones_count), 0);
    chk("t4_rst_y", 32'(y), 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_no_done", 32'(done), 0);
    end
    $display("sweep mask=1234 interrupted by reset at vec=9");

    // N=2 XOR sweep on the second instance
    @(negedge clk); #1;
    mask2 = 4'b0110; start2 = 1'b1;
    dc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid2 === 1'b1) q.push_back(int'(vec2));
      if (done2 === 1'b1 && dc < 0) dc = i;
      #1;
      if (i == 1) start2 = 1'b0;
      if (dc >= 0) break;
    end
    chk("t5_len", 32'(q.size()), 4);
    for (int j = 0; j < q.size() && j < 4; j++) chk("t5_vec_seq", 32'(q[j]), 32'(j));
    chk("t5_done_cycle", 32'(dc), 5);
    chk("t5_ones", 32'(ones2), 2);
    chk("t5_mis", 32'(mis2), 0);
    chk("t5_err", 32'(err2), 0);
    $display("sweep n=2 mask=6 done_cycle=%0d ones=%0d mis=%0d", dc, ones2, mis2);

    // Back-to-back: start held high across the end of a sweep
    @(negedge clk); #1;
    mask_in = 16'h0003; mode = 1; start = 1'b1;
    dc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dc = i; break; end
    end
    chk("t6_done_cycle", 32'(dc), 17);
    chk("t6_ones", 32'(ones_count), 2);
    chk("t6_mis", 32'(mismatch_count), 2);
    chk("t6_first", 32'(first_err_vec), 0);
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t6_restart_valid", 32'(valid), 1);
    chk("t6_restart_vec", 32'(vec), 0);
    chk("t6_restart_ones", 32'(ones_count), 0);
    chk("t6_restart_mis", 32'(mismatch_count), 0);
    chk("t6_restart_err", 32'(err_flag), 0);
    #1 start = 1'b0;
    dc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dc = i; break; end
    end
    chk("t6_second_done", 32'(dc), 16);
    chk("t6_second_mis", 32'(mismatch_count), 2);
    $display("sweep back-to-back mask=0003 second_done=%0d ones=%0d mis=%0d",
             dc, ones_count, mismatch_count);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
